// File: rtl/barrel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : barrel_pkg                                                  |
// | Brief  : Shared operation encodings for the pipelined barrel shifter |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package barrel_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_e;

endpackage
`default_nettype wire

// File: rtl/barrel_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : barrel_stage                                                |
// | Brief  : Combinational shift-by-DIST-or-0 step covering all ops      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [OP_W-1:0]  op,
  input  logic             sign,
  input  logic             en,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        OP_LSL:  data_out = {data_in[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_LSR:  data_out = {{DIST{1'b0}}, data_in[WIDTH-1:DIST]};
        // sign is the operand's original MSB, not this stage's input MSB
        OP_ASR:  data_out = {{DIST{sign}}, data_in[WIDTH-1:DIST]};
        OP_ROL:  data_out = {data_in[WIDTH-1-DIST:0], data_in[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  data_out = {data_in[DIST-1:0], data_in[WIDTH-1:DIST]};
        default: data_out = data_in;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/barrel_shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : barrel_shifter_pipe                                         |
// | Brief  : Pipelined log barrel shifter, one stage per amount bit      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic adv;

  // Single global enable: the whole pipe moves or freezes together
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar k;
  generate
    for (k = 0; k < SHW; k++) begin : g_stage
      logic [WIDTH-1:0] src_data;
      logic [WIDTH-1:0] nxt_data;
      logic [WIDTH-1:0] data_r;
      logic [OP_W-1:0]  src_op;
      logic             src_sign;
      logic             src_en;
      logic             src_valid;
      logic             valid_r;

      if (k == 0) begin : g_src
        assign src_data  = in_data;
        assign src_op    = in_op;
        assign src_sign  = in_data[WIDTH-1];
        assign src_en    = in_amt[0];
        assign src_valid = in_valid;
      end else begin : g_src
        assign src_data  = g_stage[k-1].data_r;
        assign src_op    = g_stage[k-1].g_fwd.op_r;
        assign src_sign  = g_stage[k-1].g_fwd.sign_r;
        assign src_en    = g_stage[k-1].g_fwd.amt_r[0];
        assign src_valid = g_stage[k-1].valid_r;
      end

      barrel_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_stage (
        .data_in  (src_data),
        .op       (src_op),
        .sign     (src_sign),
        .en       (src_en),
        .data_out (nxt_data)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          data_r  <= '0;
          valid_r <= 1'b0;
        end else if (adv) begin
          data_r  <= nxt_data;
          valid_r <= src_valid;
        end
      end

      // Control only travels on while later stages still need it
      if (k < SHW-1) begin : g_fwd
        logic [OP_W-1:0]  op_r;
        logic             sign_r;
        logic [SHW-2-k:0] amt_r;
        logic [SHW-2-k:0] amt_nxt;

        if (k == 0) begin : g_amt
          assign amt_nxt = in_amt[SHW-1:1];
        end else begin : g_amt
          assign amt_nxt = g_stage[k-1].g_fwd.amt_r[SHW-1-k:1];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            op_r   <= '0;
            sign_r <= 1'b0;
            amt_r  <= '0;
          end else if (adv) begin
            op_r   <= src_op;
            sign_r <= src_sign;
            amt_r  <= amt_nxt;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[SHW-1].valid_r;
  assign out_data  = g_stage[SHW-1].data_r;
  assign out_zero  = (out_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_barrel_shifter_pipe                                      |
// | Brief  : Scoreboard bench for the 8-bit pipelined barrel shifter     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int N_RND = 10000;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int n_assert = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                 input int a, input logic [2:0] op);
    logic signed [WIDTH-1:0] s;
    s = d;
    case (op)
      3'd0:    return d << a;
      3'd1:    return d >> a;
      3'd2:    return s >>> a;
      3'd3:    return (d << a) | (d >> (WIDTH - a));
      3'd4:    return (d >> a) | (d << (WIDTH - a));
      default: return d;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_assert++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_assert++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %b expected 1", out_zero); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [2:0] top [9] = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd7, 3'd1, 3'd1};
    logic [7:0] tdat[9] = '{8'hB5, 8'h96, 8'hF0, 8'h01, 8'h81, 8'h81, 8'h5A, 8'h80, 8'h01};
    logic [2:0] tamt[9] = '{3'd3, 3'd2, 3'd4, 3'd0, 3'd1, 3'd7, 3'd5, 3'd7, 3'd1};
    logic [7:0] texp[9] = '{8'hA8, 8'hE5, 8'h0F, 8'h01, 8'hC0, 8'hC0, 8'h5A, 8'h01, 8'h00};
    logic [7:0] e;
    int lat;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1;
      in_op = top[i]; in_data = tdat[i]; in_amt = tamt[i];
      exp_q.push_back(ref_shift(tdat[i], int'(tamt[i]), top[i]));
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'hXX;
      lat = 1;
      while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
      n_assert++; if (lat != 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      n_assert++; if (out_data !== texp[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h expected %h", i, out_data, texp[i]); end
      e = exp_q.pop_front();
      n_assert++; if (out_data !== e) begin n_fail++; $display("FAIL dir%0d_model: got %h expected %h", i, out_data, e); end
      n_assert++; if (out_zero !== (texp[i] == 8'h00)) begin n_fail++; $display("FAIL dir%0d_zero: got %b expected %b", i, out_zero, texp[i] == 8'h00); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int issued = 0, rx = 0, last_rx = -1;
    bit saw_drop = 0, prev_stall = 0;
    logic [7:0] held = '0, e;
    for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc < 10);
      in_valid  = (issued < 5);
      in_op     = 3'(issued % 5);
      in_data   = 8'(8'hA7 + issued * 8'h35);
      in_amt    = 3'(issued + 1);
      #1;
      if (prev_stall) begin
        n_assert++;
        if (!out_valid || out_data !== held) begin n_fail++; $display("FAIL b2b_hold: got v=%b %h expected v=1 %h", out_valid, out_data, held); end
      end
      if (out_valid && !out_ready) begin
        saw_drop = 1;
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_assert++; if (out_data !== e) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", rx, out_data, e); end
        if (last_rx >= 10) begin
          n_assert++; if (cyc != last_rx + 1) begin n_fail++; $display("FAIL b2b_gap: got cycle %0d expected %0d", cyc, last_rx + 1); end
        end
        last_rx = cyc; rx++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, int'(in_amt), in_op));
        issued++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_assert++; if (rx != 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", rx); end
    n_assert++; if (!saw_drop) begin n_fail++; $display("FAIL b2b_stall_seen: got 0 expected 1"); end
  endtask

  task automatic test_reset_inflight();
    logic [7:0] e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 3'd1; in_data = 8'hFF; in_amt = 3'(i);
      rst = (i == 2);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid%0d: got %b expected 0", i, out_valid); end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_op = 3'd2; in_data = 8'hC3; in_amt = 3'd1;
    exp_q.push_back(8'hE1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    n_assert++; if (lat != 3) begin n_fail++; $display("FAIL rst_new_latency: got %0d expected 3", lat); end
    n_assert++; if (out_data !== e) begin n_fail++; $display("FAIL rst_new_data: got %h expected %h", out_data, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int issued = 0, rx = 0;
    bit prev_stall = 0;
    logic [7:0] held = '0, e;
    for (int cyc = 0; cyc < 60000 && rx < N_RND; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (issued < N_RND) && ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        n_assert++;
        if (!out_valid || out_data !== held) begin n_fail++; $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", out_valid, out_data, held); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_assert++; n_fail++; $display("FAIL rnd_spurious: got %h expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          n_assert++; if (out_data !== e) begin n_fail++; $display("FAIL rnd_data%0d: got %h expected %h", rx, out_data, e); end
        end
        rx++;
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, int'(in_amt), in_op));
        issued++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_assert++; if (rx != N_RND) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", rx, N_RND); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
